// File: rtl/bat_seq_pkg.sv
// Shared constants for the bat_seq core: opcodes, ALU function codes,
// instruction field offsets and the sequencer state type.
package bat_seq_pkg;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int FN_LSB  = 0;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_ALU = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JNZ = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_XOR = 4'd4;
  localparam logic [3:0] FN_NOT = 4'd5;
  localparam logic [3:0] FN_INC = 4'd6;
  localparam logic [3:0] FN_DEC = 4'd7;
  localparam logic [3:0] FN_MOV = 4'd8;
  localparam logic [3:0] FN_ADC = 4'd9;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [FIELD_W-1:0] f_op(input logic [INSTR_W-1:0] ir);
    return ir[OP_LSB +: FIELD_W];
  endfunction

  function automatic logic [FIELD_W-1:0] f_rd(input logic [INSTR_W-1:0] ir);
    return ir[RD_LSB +: FIELD_W];
  endfunction

  function automatic logic [FIELD_W-1:0] f_rs(input logic [INSTR_W-1:0] ir);
    return ir[RS_LSB +: FIELD_W];
  endfunction

  function automatic logic [FIELD_W-1:0] f_fn(input logic [INSTR_W-1:0] ir);
    return ir[FN_LSB +: FIELD_W];
  endfunction

  function automatic logic [IMM_W-1:0] f_imm(input logic [INSTR_W-1:0] ir);
    return ir[IMM_LSB +: IMM_W];
  endfunction

endpackage

// File: rtl/bat_seq_alu.sv
// Combinational ALU for bat_seq_core: result, carry/borrow and zero.
// Define BAT_SEQ_ADC_EN to add fn 9 (ADC) and its carry-in port.
module bat_seq_alu
  import bat_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
`ifdef BAT_SEQ_ADC_EN
  input  logic              carry_in,
`endif
  input  logic [3:0]        fn,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              valid
);

  logic [DATA_W:0] wide;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    wide  = '0;
    valid = 1'b1;
    case (fn)
      FN_ADD:  wide = {1'b0, op_a} + {1'b0, op_b};
      FN_SUB:  wide = {1'b0, op_a} - {1'b0, op_b};
      FN_AND:  wide = {1'b0, op_a & op_b};
      FN_OR:   wide = {1'b0, op_a | op_b};
      FN_XOR:  wide = {1'b0, op_a ^ op_b};
      FN_NOT:  wide = {1'b0, ~op_a};
      FN_INC:  wide = {1'b0, op_a} + {{DATA_W{1'b0}}, 1'b1};
      FN_DEC:  wide = {1'b0, op_a} - {{DATA_W{1'b0}}, 1'b1};
      FN_MOV:  wide = {1'b0, op_b};
`ifdef BAT_SEQ_ADC_EN
      FN_ADC:  wide = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, carry_in};
`endif
      default: valid = 1'b0;
    endcase
    // Subtraction wraps in DATA_W+1 bits, so the top bit is the borrow.
    result = wide[DATA_W-1:0];
    carry  = wide[DATA_W];
    zero   = (result == '0);
  end

endmodule

// File: rtl/bat_seq_core.sv
// Multi-cycle fetch/execute core with req/ack memory port, Z/C flags and HALT.
// Define BAT_SEQ_ADC_EN to enable the ADC instruction (ALU fn 9).
module bat_seq_core
  import bat_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HALT,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [DATA_W-1:0] OUT,
  output logic              STOPPED
);

  localparam int RIDX_W = $clog2(NREGS);

  // Full 4-bit field compare keeps every instruction bit in use for any NREGS.
  function automatic logic [RIDX_W-1:0] reg_idx(input logic [FIELD_W-1:0] field);
    reg_idx = '0;
    for (int i = 0; i < 16; i++)
      if (field == 4'(i)) reg_idx = RIDX_W'(i % NREGS);
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                z_q, z_d;
  logic                c_q, c_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];

  logic [FIELD_W-1:0]  op;
  logic [RIDX_W-1:0]   rd_idx, rs_idx;
  logic [DATA_W-1:0]   rd_val, rs_val;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_z, alu_vld;
  logic                mem_req, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  assign op     = f_op(ir_q);
  assign rd_idx = reg_idx(f_rd(ir_q));
  assign rs_idx = reg_idx(f_rs(ir_q));
  assign rd_val = regs_q[rd_idx];
  assign rs_val = regs_q[rs_idx];

  bat_seq_alu #(.DATA_W(DATA_W)) u_alu (
`ifdef BAT_SEQ_ADC_EN
    .carry_in (c_q),
`endif
    .fn       (f_fn(ir_q)),
    .op_a     (rd_val),
    .op_b     (rs_val),
    .result   (alu_res),
    .carry    (alu_c),
    .zero     (alu_z),
    .valid    (alu_vld)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    z_d       = z_q;
    c_d       = c_q;
    regs_d    = regs_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      ST_FETCH: begin
        if (!HALT) begin
          mem_req  = 1'b1;
          mem_addr = pc_q;
          if (MEM_ACK) begin
            ir_d    = MEM_RDATA[INSTR_W-1:0];
            pc_d    = pc_q + ADDR_W'(1);
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op)
          OP_LDI: regs_d[rd_idx] = DATA_W'(f_imm(ir_q));
          OP_LD, OP_ST: state_d = ST_MEM;
          OP_ALU: begin
            if (alu_vld) begin
              regs_d[rd_idx] = alu_res;
              z_d = alu_z;
              c_d = alu_c;
            end
          end
          OP_JMP: pc_d = ADDR_W'(rs_val);
          OP_JZ:  if (z_q)  pc_d = ADDR_W'(rs_val);
          OP_JNZ: if (!z_q) pc_d = ADDR_W'(rs_val);
          OP_HLT: state_d = ST_DONE;
          default: ;
        endcase
      end

      ST_MEM: begin
        mem_req   = 1'b1;
        mem_we    = (op == OP_ST);
        mem_addr  = ADDR_W'(rs_val);
        mem_wdata = (op == OP_ST) ? rd_val : '0;
        if (MEM_ACK) begin
          if (op == OP_LD) regs_d[rd_idx] = MEM_RDATA;
          state_d = ST_FETCH;
        end
      end

      ST_DONE: ;

      default: state_d = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      // NOTE: the register file is flops, not RAM, so it is cleared on reset.
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      c_q     <= c_d;
      regs_q  <= regs_d;
    end
  end

  // Memory port is silenced while reset is held, since FETCH would otherwise request.
  assign MEM_REQ   = RST & mem_req;
  assign MEM_WE    = RST & mem_we;
  assign MEM_ADDR  = RST ? mem_addr  : '0;
  assign MEM_WDATA = RST ? mem_wdata : '0;
  assign OUT       = regs_q[NREGS-1];
  assign STOPPED   = (state_q == ST_DONE);

endmodule

// File: tb/tb_bat_seq_core.sv
// Directed self-checking bench for bat_seq_core with a variable-latency memory model.
module tb_bat_seq_core;
  import bat_seq_pkg::*;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int ADDR_W = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              HALT = 1'b0;
  logic              MEM_REQ, MEM_WE, MEM_ACK;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA, MEM_RDATA, OUT;
  logic              STOPPED;

  bat_seq_core #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .HALT      (HALT),
    .MEM_REQ   (MEM_REQ),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_ACK   (MEM_ACK),
    .MEM_RDATA (MEM_RDATA),
    .OUT       (OUT),
    .STOPPED   (STOPPED)
  );

  always #5 CLK = ~CLK;

  // Memory model: ack after ack_delay wait cycles; loader port used while in reset.
  logic [15:0] mem [0:511];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  bit          stray_ack = 1'b0;
  logic        ld_we     = 1'b0;
  logic [8:0]  ld_addr   = '0;
  logic [15:0] ld_data   = '0;
  int          wr_cnt    = 0;
  logic [15:0] wr_addr   = '0;
  logic [15:0] wr_data   = '0;

  assign MEM_ACK   = (MEM_REQ && (wait_cnt >= ack_delay)) || stray_ack;
  assign MEM_RDATA = mem[MEM_ADDR[8:0]];

  always @(posedge CLK) begin
    if (MEM_REQ && !MEM_ACK) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (MEM_REQ && MEM_ACK && MEM_WE) begin
      mem[MEM_ADDR[8:0]] <= MEM_WDATA;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= MEM_ADDR;
      wr_data <= MEM_WDATA;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] i_ldi(input int rd, input int imm);
    return {OP_LDI, 4'(rd), 8'(imm)};
  endfunction
  function automatic logic [15:0] i_alu(input int rd, input int rs, input logic [3:0] fn);
    return {OP_ALU, 4'(rd), 4'(rs), fn};
  endfunction
  function automatic logic [15:0] i_ld(input int rd, input int rs);
    return {OP_LD, 4'(rd), 4'(rs), 4'h0};
  endfunction
  function automatic logic [15:0] i_st(input int rd, input int rs);
    return {OP_ST, 4'(rd), 4'(rs), 4'h0};
  endfunction
  function automatic logic [15:0] i_jmp(input logic [3:0] op, input int rs);
    return {op, 4'h0, 4'(rs), 4'h0};
  endfunction
  localparam logic [15:0] I_HLT = 16'hF000;

  logic [15:0] prog [$];

  task automatic poke(input logic [8:0] a, input logic [15:0] d);
    ld_addr = a;
    ld_data = d;
    ld_we   = 1'b1;
    @(negedge CLK);
    ld_we   = 1'b0;
  endtask

  task automatic load_prog(input logic [8:0] base);
    foreach (prog[i]) poke(base + 9'(i), prog[i]);
  endtask

  task automatic enter_reset();
    @(negedge CLK);
    RST       = 1'b0;
    HALT      = 1'b0;
    stray_ack = 1'b0;
    @(negedge CLK);
  endtask

  task automatic start_run();
    @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  task automatic wait_stopped(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!STOPPED && n < budget);
    check({tag, " stopped"}, 32'(STOPPED), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  found;
    bit  seen;
    int  w0;

    // Reset state
    enter_reset();
    check("rst mem_req", 32'(MEM_REQ), 0);
    check("rst mem_addr", 32'(MEM_ADDR), 0);
    check("rst out", 32'(OUT), 0);
    check("rst stopped", 32'(STOPPED), 0);

    // Slow first fetch: LDI R1,5 with ack three cycles late
    ack_delay = 3;
    prog = {i_ldi(1, 8'h05), i_alu(7, 1, FN_MOV), I_HLT};
    load_prog(9'h000);
    start_run();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (MEM_REQ) n++;
      if (MEM_REQ && MEM_ACK) break;
    end
    check("s1 req cycles", 32'(n), 4);
    check("s1 fetch addr", 32'(MEM_ADDR), 0);
    @(negedge CLK);
    check("s1 exec req low", 32'(MEM_REQ), 0);
    @(negedge CLK);
    check("s1 next fetch req", 32'(MEM_REQ), 1);
    check("s1 pc", 32'(MEM_ADDR), 1);
    wait_stopped("s1", 100, n);
    check("s1 r1 via out", 32'(OUT), 32'h0005);

    // ADD overflow to zero, then JZ taken and JNZ not taken
    enter_reset();
    ack_delay = 0;
    prog = {i_ldi(1, 0), i_alu(1, 0, FN_DEC), i_ldi(2, 1), i_ldi(3, 8'h40),
            i_alu(1, 2, FN_ADD), i_jmp(OP_JZ, 3), i_ldi(7, 8'hEE), I_HLT};
    load_prog(9'h000);
    prog = {i_jmp(OP_JNZ, 3), i_ldi(4, 8'h80), i_st(1, 4), i_ldi(7, 8'h40), I_HLT};
    load_prog(9'h040);
    w0 = wr_cnt;
    start_run();
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (MEM_REQ && MEM_ACK && MEM_ADDR == 16'h0005) begin
        found = 1'b1;
        break;
      end
    end
    check("s2 jz fetched", 32'(found), 1);
    @(negedge CLK);
    @(negedge CLK);
    check("s2 jz target req", 32'(MEM_REQ), 1);
    check("s2 jz target addr", 32'(MEM_ADDR), 32'h0040);
    wait_stopped("s2", 100, n);
    check("s2 z flag", 32'(dut.z_q), 1);
    check("s2 c flag", 32'(dut.c_q), 1);
    check("s2 out", 32'(OUT), 32'h0040);
    check("s2 store count", 32'(wr_cnt - w0), 1);
    check("s2 store addr", 32'(wr_addr), 32'h0080);
    check("s2 store data r1", 32'(wr_data), 32'h0000);

    // Store then load through the memory model, with exact cycle count
    enter_reset();
    prog = {i_ldi(4, 8'h80), i_alu(4, 4, FN_ADD), i_ldi(5, 8'hBE)};
    for (int k = 0; k < 8; k++) prog.push_back(i_alu(5, 5, FN_ADD));
    prog.push_back(i_ldi(6, 8'hEF));
    prog.push_back(i_alu(5, 6, FN_OR));
    prog.push_back(i_st(5, 4));
    prog.push_back(i_ld(6, 4));
    prog.push_back(i_alu(7, 6, FN_MOV));
    prog.push_back(I_HLT);
    load_prog(9'h000);
    w0 = wr_cnt;
    start_run();
    wait_stopped("s3", 200, n);
    check("s3 cycles to stop", 32'(n), 37);
    check("s3 store count", 32'(wr_cnt - w0), 1);
    check("s3 store addr", 32'(wr_addr), 32'h0100);
    check("s3 store data", 32'(wr_data), 32'hBEEF);
    check("s3 load via out", 32'(OUT), 32'hBEEF);

    // HALT raised during a load's memory phase; stray ack while paused
    enter_reset();
    ack_delay = 2;
    poke(9'h090, 16'h1357);
    prog = {i_ldi(4, 8'h90), i_ld(7, 4), I_HLT};
    load_prog(9'h000);
    start_run();
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (MEM_REQ && !MEM_WE && MEM_ADDR == 16'h0090) begin
        found = 1'b1;
        break;
      end
    end
    check("s4 load request", 32'(found), 1);
    HALT = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (MEM_ACK) begin
        found = 1'b1;
        break;
      end
    end
    check("s4 load acked", 32'(found), 1);
    @(negedge CLK);
    check("s4 halted req", 32'(MEM_REQ), 0);
    check("s4 load data out", 32'(OUT), 32'h1357);
    stray_ack = 1'b1;
    @(negedge CLK);
    stray_ack = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      seen |= MEM_REQ;
    end
    check("s4 req while halted", 32'(seen), 0);
    HALT = 1'b0;
    @(negedge CLK);
    check("s4 resume req", 32'(MEM_REQ), 1);
    check("s4 resume pc", 32'(MEM_ADDR), 2);
    wait_stopped("s4", 100, n);

    // fn 9: ADC when compiled in, otherwise a flag-preserving NOP
    enter_reset();
    ack_delay = 0;
    prog = {i_ldi(1, 0), i_alu(1, 0, FN_DEC), i_ldi(2, 2), i_ldi(3, 3),
            i_alu(2, 3, 4'd9), i_ldi(4, 8'hA0), i_st(2, 4), i_ld(7, 4), I_HLT};
    load_prog(9'h000);
    start_run();
    wait_stopped("s6", 100, n);
`ifdef BAT_SEQ_ADC_EN
    check("s6 adc result", 32'(OUT), 32'h0006);
    check("s6 adc carry", 32'(dut.c_q), 0);
`else
    check("s6 fn9 rd kept", 32'(OUT), 32'h0002);
    check("s6 fn9 carry kept", 32'(dut.c_q), 1);
`endif
    check("s6 z flag", 32'(dut.z_q), 0);

    // Logic/arith sweep including undefined opcode and fn codes
    enter_reset();
    prog = {i_ldi(1, 8'h5A), i_ldi(2, 8'h0F), i_alu(1, 2, FN_AND), i_alu(1, 2, FN_XOR),
            i_alu(1, 0, FN_NOT), i_alu(1, 0, FN_INC), i_alu(1, 2, FN_SUB), 16'h5123,
            i_alu(1, 2, 4'hC), i_alu(7, 1, FN_MOV), I_HLT};
    load_prog(9'h000);
    start_run();
    wait_stopped("s7", 100, n);
    check("s7 alu chain", 32'(OUT), 32'hFFEC);

    // R7 via LDI+MOV, then HLT and reset from DONE
    enter_reset();
    prog = {i_ldi(1, 8'h12)};
    for (int k = 0; k < 8; k++) prog.push_back(i_alu(1, 1, FN_ADD));
    prog.push_back(i_ldi(2, 8'h34));
    prog.push_back(i_alu(1, 2, FN_OR));
    prog.push_back(i_alu(7, 1, FN_MOV));
    prog.push_back(I_HLT);
    load_prog(9'h000);
    start_run();
    wait_stopped("s5", 100, n);
    check("s5 out", 32'(OUT), 32'h1234);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      seen |= MEM_REQ;
    end
    check("s5 no req after hlt", 32'(seen), 0);
    check("s5 still stopped", 32'(STOPPED), 1);
    RST = 1'b0;
    @(negedge CLK);
    check("s5 rst out", 32'(OUT), 0);
    check("s5 rst stopped", 32'(STOPPED), 0);
    check("s5 rst req/we", 32'({MEM_REQ, MEM_WE}), 0);
    check("s5 rst addr", 32'(MEM_ADDR), 0);
    check("s5 rst wdata", 32'(MEM_WDATA), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
